// File: rtl/phys_free_list_if.sv
// Rename/retire-facing bundle for the physical-register free list.
// The master side is rename + retire; the slave side is the free list itself.
interface phys_free_list_if #(
  parameter int PTAG_W = 6
);
  logic              alloc_req_1;
  logic              alloc_req_2;
  logic              alloc_avail_1;
  logic              alloc_avail_2;
  logic [PTAG_W-1:0] alloc_tag_1;
  logic [PTAG_W-1:0] alloc_tag_2;
  logic              rt_flag_1;
  logic [PTAG_W-1:0] fp_i_1;
  logic              rt_flag_2;
  logic [PTAG_W-1:0] fp_i_2;
  logic [PTAG_W:0]   free_count;
  logic              err_dbl_free;
  logic              err_overflow;

  modport master (
    output alloc_req_1, alloc_req_2,
    output rt_flag_1, fp_i_1, rt_flag_2, fp_i_2,
    input  alloc_avail_1, alloc_avail_2, alloc_tag_1, alloc_tag_2,
    input  free_count, err_dbl_free, err_overflow
  );

  modport slave (
    input  alloc_req_1, alloc_req_2,
    input  rt_flag_1, fp_i_1, rt_flag_2, fp_i_2,
    output alloc_avail_1, alloc_avail_2, alloc_tag_1, alloc_tag_2,
    output free_count, err_dbl_free, err_overflow
  );
endinterface

// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free tags, two pops and two
// pushes per cycle, with a free-bit vector that catches double releases.
module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PTAG_W    = 6
) (
  input logic              i_clk,
  input logic              i_rst,
  phys_free_list_if.slave  bus
);

  logic [PTAG_W-1:0]    r_fifo [NUM_PREGS];
  logic [PTAG_W-1:0]    r_head;
  logic [PTAG_W-1:0]    r_tail;
  logic [PTAG_W:0]      r_count;
  logic [NUM_PREGS-1:0] r_free_vec;
  logic                 r_err_dbl;
  logic                 r_err_ovf;

  logic                 w_avail_1;
  logic                 w_avail_2;
  logic [PTAG_W-1:0]    w_tag_1;
  logic [PTAG_W-1:0]    w_tag_2;
  logic                 w_g1;
  logic                 w_g2;
  logic [1:0]           w_pops;
  logic [PTAG_W:0]      w_base;
  logic                 w_vld_1;
  logic                 w_vld_2;
  logic                 w_is_free_1;
  logic                 w_is_free_2;
  logic                 w_full_1;
  logic                 w_full_2;
  logic                 w_acc_1;
  logic                 w_acc_2;
  logic                 w_dbl_1;
  logic                 w_dbl_2;
  logic                 w_ovf_1;
  logic                 w_ovf_2;
  logic [1:0]           w_pushes;
  logic [PTAG_W-1:0]    w_tail_2;
  logic [PTAG_W-1:0]    w_head_next;
  logic [PTAG_W-1:0]    w_tail_next;
  logic [PTAG_W:0]      w_count_next;
  logic [NUM_PREGS-1:0] w_clr_mask;
  logic [NUM_PREGS-1:0] w_set_mask;
  logic [NUM_PREGS-1:0] w_free_vec_next;

  // Advance a FIFO pointer by 0..2 entries, wrapping at NUM_PREGS.
  function automatic logic [PTAG_W-1:0] ptr_add(input logic [PTAG_W-1:0] p,
                                                input logic [1:0] inc);
    logic [PTAG_W+1:0] s;
    s = {2'b00, p} + {{PTAG_W{1'b0}}, inc};
    if (s >= (PTAG_W+2)'(NUM_PREGS)) begin
      s = s - (PTAG_W+2)'(NUM_PREGS);
    end else begin
      s = s;
    end
    return s[PTAG_W-1:0];
  endfunction

  // Zero-latency allocation view straight off the registered queue head.
  always_comb begin
    w_avail_1 = (r_count != {(PTAG_W+1){1'b0}});
    w_avail_2 = (r_count >= (PTAG_W+1)'(2));
    w_tag_1   = r_fifo[r_head];
    w_tag_2   = r_fifo[ptr_add(r_head, 2'd1)];
    w_g1      = bus.alloc_req_1 & w_avail_1;
    w_g2      = bus.alloc_req_2 & bus.alloc_req_1 & w_avail_2;
    w_pops    = {1'b0, w_g1} + {1'b0, w_g2};
    w_base    = r_count - {{(PTAG_W-1){1'b0}}, w_pops};
  end

  // Release arbitration: slot 1 sees the pre-release state, slot 2 sees slot 1's push.
  always_comb begin
    w_vld_1     = bus.rt_flag_1 & (bus.fp_i_1 != {PTAG_W{1'b0}});
    w_is_free_1 = r_free_vec[bus.fp_i_1];
    w_full_1    = (w_base == (PTAG_W+1)'(NUM_PREGS));
    w_acc_1     = w_vld_1 & ~w_is_free_1 & ~w_full_1;
    w_dbl_1     = w_vld_1 & w_is_free_1;
    w_ovf_1     = w_vld_1 & ~w_is_free_1 & w_full_1;

    w_vld_2     = bus.rt_flag_2 & (bus.fp_i_2 != {PTAG_W{1'b0}});
    w_is_free_2 = r_free_vec[bus.fp_i_2] | (w_acc_1 & (bus.fp_i_2 == bus.fp_i_1));
    w_full_2    = ((w_base + {{PTAG_W{1'b0}}, w_acc_1}) == (PTAG_W+1)'(NUM_PREGS));
    w_acc_2     = w_vld_2 & ~w_is_free_2 & ~w_full_2;
    w_dbl_2     = w_vld_2 & w_is_free_2;
    w_ovf_2     = w_vld_2 & ~w_is_free_2 & w_full_2;

    w_pushes    = {1'b0, w_acc_1} + {1'b0, w_acc_2};
  end

  // Next pointers, occupancy and free-bit vector.
  always_comb begin
    w_tail_2     = ptr_add(r_tail, {1'b0, w_acc_1});
    w_head_next  = ptr_add(r_head, w_pops);
    w_tail_next  = ptr_add(r_tail, w_pushes);
    w_count_next = w_base + {{(PTAG_W-1){1'b0}}, w_pushes};
    // Popped tags are always free and accepted pushes never are, so masks cannot collide.
    w_clr_mask   = ({{(NUM_PREGS-1){1'b0}}, w_g1} << w_tag_1)
                 | ({{(NUM_PREGS-1){1'b0}}, w_g2} << w_tag_2);
    w_set_mask   = ({{(NUM_PREGS-1){1'b0}}, w_acc_1} << bus.fp_i_1)
                 | ({{(NUM_PREGS-1){1'b0}}, w_acc_2} << bus.fp_i_2);
    w_free_vec_next = (r_free_vec & ~w_clr_mask) | w_set_mask;
  end

  // State update; reset rebuilds the identity map p0..p31 -> x0..x31.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_fifo[i]     <= (i < NUM_PREGS - NUM_AREGS) ? PTAG_W'(NUM_AREGS + i) : {PTAG_W{1'b0}};
        r_free_vec[i] <= (i >= NUM_AREGS);
      end
      r_head    <= {PTAG_W{1'b0}};
      r_tail    <= PTAG_W'(NUM_PREGS - NUM_AREGS);
      r_count   <= (PTAG_W+1)'(NUM_PREGS - NUM_AREGS);
      r_err_dbl <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_acc_1) begin
        r_fifo[r_tail] <= bus.fp_i_1;
      end
      if (w_acc_2) begin
        r_fifo[w_tail_2] <= bus.fp_i_2;
      end
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_count    <= w_count_next;
      r_free_vec <= w_free_vec_next;
      r_err_dbl  <= r_err_dbl | w_dbl_1 | w_dbl_2;
      r_err_ovf  <= r_err_ovf | w_ovf_1 | w_ovf_2;
    end
  end

  assign bus.alloc_avail_1 = w_avail_1;
  assign bus.alloc_avail_2 = w_avail_2;
  assign bus.alloc_tag_1   = w_tag_1;
  assign bus.alloc_tag_2   = w_tag_2;
  assign bus.free_count    = r_count;
  assign bus.err_dbl_free  = r_err_dbl;
  assign bus.err_overflow  = r_err_ovf;

endmodule
